// File: rtl/instr_encoder_loader.sv
// Encodes symbolic RV32I-subset instructions into 32-bit words and streams them
// sequentially into instruction memory, one word per cycle, during a load session.
module instr_encoder_loader #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              finish,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              err,
  output logic [7:0]        err_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_ADDI = 4'd4;
  localparam logic [3:0] OP_LW   = 4'd5;
  localparam logic [3:0] OP_SW   = 4'd6;
  localparam logic [3:0] OP_BEQ  = 4'd7;
  localparam logic [3:0] OP_BNE  = 4'd8;
  localparam logic [3:0] OP_JAL  = 4'd9;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  state_t              state_q, state_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                err_q, err_d;
  logic [7:0]          err_cnt_q, err_cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;

  logic [31:0]         enc;
  logic                legal;
  logic                accept;
  logic signed [31:0]  imm_s;
  logic                fits_12, fits_b, fits_j;

  assign imm_s   = $signed(in_imm);
  assign fits_12 = (imm_s >= -32'sd2048) && (imm_s <= 32'sd2047);
  assign fits_b  = (imm_s >= -32'sd4096) && (imm_s <= 32'sd4094) && !in_imm[0];
  assign fits_j  = (imm_s >= -32'sd1048576) && (imm_s <= 32'sd1048574) && !in_imm[0];

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    enc   = 32'h0;
    legal = 1'b0;
    unique case (in_op)
      OP_ADD:  begin enc = {7'b0000000, in_rs2, in_rs1, 3'b000, in_rd, 7'b0110011}; legal = 1'b1; end
      OP_SUB:  begin enc = {7'b0100000, in_rs2, in_rs1, 3'b000, in_rd, 7'b0110011}; legal = 1'b1; end
      OP_AND:  begin enc = {7'b0000000, in_rs2, in_rs1, 3'b111, in_rd, 7'b0110011}; legal = 1'b1; end
      OP_OR:   begin enc = {7'b0000000, in_rs2, in_rs1, 3'b110, in_rd, 7'b0110011}; legal = 1'b1; end
      OP_ADDI: begin enc = {in_imm[11:0], in_rs1, 3'b000, in_rd, 7'b0010011}; legal = fits_12; end
      OP_LW:   begin enc = {in_imm[11:0], in_rs1, 3'b010, in_rd, 7'b0000011}; legal = fits_12; end
      OP_SW: begin
        enc   = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], 7'b0100011};
        legal = fits_12;
      end
      OP_BEQ, OP_BNE: begin
        enc   = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, (in_op == OP_BNE) ? 3'b001 : 3'b000,
                 in_imm[4:1], in_imm[11], 7'b1100011};
        legal = fits_b;
      end
      OP_JAL: begin
        enc   = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, 7'b1101111};
        legal = fits_j;
      end
      default: begin enc = 32'h0; legal = 1'b0; end
    endcase
  end

  assign busy     = (state_q == S_LOAD);
  assign done     = (state_q == S_DONE);
  assign full     = (count_q == DEPTH_C);
  // count advances on the accept edge, so full already covers any in-flight write
  assign in_ready = busy && !full;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    err_d     = err_q;
    err_cnt_d = err_cnt_q;
    we_d      = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d   = S_LOAD;
          count_d   = '0;
          err_d     = 1'b0;
          err_cnt_d = 8'd0;
        end
      end
      S_LOAD: begin
        if (finish) state_d = S_DONE;
        if (accept) begin
          if (legal) begin
            we_d    = 1'b1;
            addr_d  = count_q[ADDR_W-1:0];
            wdata_d = enc;
            count_d = count_q + 1'b1;
            if (count_d == DEPTH_C) state_d = S_DONE;
          end else begin
            err_d = 1'b1;
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= 8'd0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= 32'h0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign count      = count_q;
  assign err        = err_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader with a small memory so the full/auto-done
// boundary is reachable; expected words are hand-assembled RV32I encodings.
module tb_instr_encoder_loader;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 2;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              finish;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_op;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [31:0]       in_imm;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              busy;
  logic              done;
  logic              full;
  logic [ADDR_W:0]   count;
  logic              err;
  logic [7:0]        err_cnt;

  instr_encoder_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .finish     (finish),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_rd      (in_rd),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_imm     (in_imm),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .busy       (busy),
    .done       (done),
    .full       (full),
    .count      (count),
    .err        (err),
    .err_cnt    (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc++;

  // write log captured away from the active edge
  logic [ADDR_W-1:0] w_addr[$];
  logic [31:0]       w_data[$];
  int                w_cyc[$];

  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      w_addr.push_back(imem_addr);
      w_data.push_back(imem_wdata);
      w_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    w_addr.delete();
    w_data.delete();
    w_cyc.delete();
  endtask

  task automatic drive(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [31:0] imm);
    in_op    = op;
    in_rd    = rd;
    in_rs1   = rs1;
    in_rs2   = rs2;
    in_imm   = imm;
    in_valid = 1'b1;
  endtask

  // Leaves in_valid high so back-to-back calls stream one per cycle.
  task automatic send(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] imm);
    bit ok;
    ok = 1'b0;
    drive(op, rd, rs1, rs2, imm);
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (in_ready === 1'b1) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    check("accept_within_budget", 32'(ok), 32'd1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic pulse_finish();
    finish = 1'b1;
    @(posedge clk);
    #1;
    finish = 1'b0;
  endtask

  int acc;

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    finish   = 1'b0;
    in_valid = 1'b0;
    in_op    = '0;
    in_rd    = '0;
    in_rs1   = '0;
    in_rs2   = '0;
    in_imm   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_we", 32'(imem_we), 32'd0);
    check("reset_busy_done_full", {29'd0, busy, done, full}, 32'd0);
    check("reset_count", 32'(count), 32'd0);
    check("reset_err", {23'd0, err, err_cnt}, 32'd0);
    check("reset_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // ADD/SUB, finish one cycle after the last accept
    clear_log();
    pulse_start();
    check("t1_busy", 32'(busy), 32'd1);
    send(4'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    send(4'd1, 5'd5, 5'd6, 5'd7, 32'd0);
    in_valid = 1'b0;
    finish   = 1'b1;
    @(negedge clk);
    check("t1_sub_we", 32'(imem_we), 32'd1);
    check("t1_sub_addr", 32'(imem_addr), 32'd1);
    check("t1_done_not_yet", 32'(done), 32'd0);
    @(posedge clk);
    #1;
    finish = 1'b0;
    @(negedge clk);
    check("t1_done", 32'(done), 32'd1);
    check("t1_we_low", 32'(imem_we), 32'd0);
    check("t1_count", 32'(count), 32'd2);
    check("t1_nwrites", 32'(w_data.size()), 32'd2);
    if (w_data.size() == 2) begin
      check("t1_addr0", 32'(w_addr[0]), 32'd0);
      check("t1_add", w_data[0], 32'h002081B3);
      check("t1_addr1", 32'(w_addr[1]), 32'd1);
      check("t1_sub", w_data[1], 32'h407302B3);
    end
    @(posedge clk);
    #1;

    // ADDI/LW/SW streamed
    clear_log();
    pulse_start();
    check("t2_count_cleared", 32'(count), 32'd0);
    send(4'd4, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF);
    send(4'd5, 5'd2, 5'd1, 5'd0, 32'd8);
    send(4'd6, 5'd0, 5'd1, 5'd2, 32'd4);
    idle(2);
    check("t2_nwrites", 32'(w_data.size()), 32'd3);
    if (w_data.size() == 3) begin
      check("t2_addi", w_data[0], 32'hFFF00093);
      check("t2_lw", w_data[1], 32'h0080A103);
      check("t2_sw", w_data[2], 32'h0020A223);
      check("t2_addr2", 32'(w_addr[2]), 32'd2);
      check("t2_gap01", 32'(w_cyc[1] - w_cyc[0]), 32'd1);
      check("t2_gap12", 32'(w_cyc[2] - w_cyc[1]), 32'd1);
    end
    pulse_finish();

    // BEQ / JAL
    clear_log();
    pulse_start();
    send(4'd7, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC);
    send(4'd9, 5'd1, 5'd0, 5'd0, 32'd8);
    idle(2);
    check("t3_nwrites", 32'(w_data.size()), 32'd2);
    if (w_data.size() == 2) begin
      check("t3_beq", w_data[0], 32'hFE208EE3);
      check("t3_jal", w_data[1], 32'h008000EF);
    end
    pulse_finish();

    // rejections
    clear_log();
    pulse_start();
    send(4'd4, 5'd1, 5'd0, 5'd0, 32'd2048);
    send(4'd7, 5'd0, 5'd1, 5'd2, 32'd3);
    send(4'd12, 5'd1, 5'd1, 5'd1, 32'd0);
    idle(2);
    check("t4_no_writes", 32'(w_data.size()), 32'd0);
    check("t4_err", 32'(err), 32'd1);
    check("t4_err_cnt", 32'(err_cnt), 32'd3);
    check("t4_count", 32'(count), 32'd0);
    send(4'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    idle(2);
    check("t4_nwrites_after", 32'(w_data.size()), 32'd1);
    if (w_data.size() == 1) begin
      check("t4_addr", 32'(w_addr[0]), 32'd0);
      check("t4_add", w_data[0], 32'h002081B3);
    end
    pulse_finish();

    // fill to DEPTH with 6 offered back-to-back
    clear_log();
    pulse_start();
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      drive(4'd4, 5'd1, 5'd0, 5'd0, 32'(i + 1));
      @(negedge clk);
      if (in_ready === 1'b1) acc++;
      if (i >= 4) check($sformatf("t5_ready_low_%0d", i), 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    idle(2);
    check("t5_accepted", 32'(acc), 32'd4);
    check("t5_nwrites", 32'(w_data.size()), 32'd4);
    if (w_data.size() == 4) begin
      for (int i = 0; i < 4; i++)
        check($sformatf("t5_addr%0d", i), 32'(w_addr[i]), 32'(i));
      check("t5_last", w_data[3], 32'h00400093);
    end
    check("t5_full", 32'(full), 32'd1);
    check("t5_done", 32'(done), 32'd1);
    check("t5_count", 32'(count), 32'(DEPTH));

    // reset mid-session, the cycle after an accept
    clear_log();
    pulse_start();
    send(4'd15, 5'd1, 5'd1, 5'd1, 32'd0);
    send(4'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("t6_we", 32'(imem_we), 32'd0);
    check("t6_addr_data", {imem_wdata[29:0], imem_addr}, 32'd0);
    check("t6_flags", {29'd0, busy, done, full}, 32'd0);
    check("t6_count", 32'(count), 32'd0);
    check("t6_err", {23'd0, err, err_cnt}, 32'd0);
    @(negedge clk);
    check("t6_no_write", 32'(w_data.size()), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    pulse_start();
    send(4'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    idle(2);
    check("t6_nwrites", 32'(w_data.size()), 32'd1);
    if (w_data.size() == 1) begin
      check("t6_addr0", 32'(w_addr[0]), 32'd0);
      check("t6_add", w_data[0], 32'h002081B3);
    end
    check("t6_err_clear", 32'(err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
Encoder and program loader for the RV32I subset that the pipeline's control decoder understands. It accepts symbolic instructions (op, rd, rs1, rs2, imm) over a valid/ready handshake and encodes each one into a 32-bit RV32I word. It writes the words sequentially into instruction memory, so benches and boot logic can build programs without hand-assembled hex. It sits in front of the imem write port; the fetch/decode path reads back what it writes.

Parameters:
DEPTH, 256, instruction memory depth in words; the loader never writes beyond it.
ADDR_W, $clog2(DEPTH), width of the word address.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  pulse; begins a load session at word 0
finish  input  1  pulse; ends the session
in_valid  input  1  instruction present
in_ready  output  1  loader can accept an instruction this cycle
in_op  input  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 ADDI, 5 LW, 6 SW, 7 BEQ, 8 BNE, 9 JAL; 10-15 illegal
in_rd  input  5  destination register
in_rs1  input  5  source register 1
in_rs2  input  5  source register 2
in_imm  input  32  signed byte immediate/offset
imem_we  output  1  write strobe, one cycle per word
imem_addr  output  ADDR_W  word address
imem_wdata  output  32  encoded instruction
busy  output  1  session active (LOAD state)
done  output  1  session ended (DONE state)
full  output  1  count == DEPTH
count  output  ADDR_W+1  number of words written this session
err  output  1  sticky; one or more instructions rejected
err_cnt  output  8  rejected-instruction count, saturates at 255

Behaviour:
- Reset (asynchronous, rst_n low): state IDLE. All outputs 0. Any pending write is dropped.
- FSM states:
  - IDLE: start -> LOAD. On that transition, clear count, err and err_cnt.
  - LOAD: finish -> DONE. Also go to DONE automatically on the cycle the write that makes count reach DEPTH occurs.
  - DONE: hold all outputs. start -> LOAD with the same clears as from IDLE.
  - start in LOAD is ignored. finish in IDLE or DONE is ignored.
- in_ready = busy && !full && !(a pending write would make count == DEPTH). This is combinational from registered state.
- Transfer occurs when in_valid && in_ready. Words are written in order at addresses 0,1,2,...
- Latency and throughput:
  - A legal instruction accepted at cycle N is written at N+1: imem_we=1, imem_addr = old count, imem_wdata = encoded word.
  - count increments at the same edge that raises imem_we.
  - Throughput is one instruction per cycle.
- Encoding:
  - R-type, opcode 0110011: funct7|rs2|rs1|funct3|rd|opcode.
    - ADD: f7=0000000, f3=000. SUB: f7=0100000, f3=000.
    - AND: f7=0000000, f3=111. OR: f7=0000000, f3=110.
  - ADDI: imm[11:0]|rs1|000|rd|0010011.
  - LW: imm[11:0]|rs1|010|rd|0000011.
  - SW: imm[11:5]|rs2|rs1|010|imm[4:0]|0100011.
  - BEQ (f3=000) and BNE (f3=001): imm[12]|imm[10:5]|rs2|rs1|f3|imm[4:1]|imm[11]|1100011.
  - JAL: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|1101111.
  - Unused fields are encoded exactly as given; rd, rs1 and rs2 are not validated.
- Rejection rules (checked on accept):
  - Illegal op.
  - I/S immediate outside [-2048, 2047].
  - B immediate outside [-4096, 4094] or odd.
  - JAL immediate outside [-1048576, 1048574] or odd.
- Rejected instruction handling: it is still handshaked (consumed). No write occurs, count is unchanged, err is set, err_cnt increments (saturating).
- Simultaneous events:
  - finish with an accepted instruction in the same cycle: the instruction is processed and written at N+1, and DONE is entered at the same edge.
  - A pending write always completes before done rises.
- Reset mid-session: immediate return to IDLE; no further imem_we.

Test Plan:
- start; ADD x3,x1,x2; SUB x5,x6,x7; finish -> writes 0x002081B3 at addr 0 and 0x407302B3 at addr 1; count=2; done=1 one cycle after the last write.
- ADDI x1,x0,-1; LW x2,8(x1); SW x2,4(x1) streamed with in_valid held high -> 0xFFF00093, 0x0080A103, 0x0020A223 on consecutive cycles, one write per cycle.
- BEQ x1,x2,-4 then JAL x1,8 -> 0xFE208EE3 then 0x008000EF.
- ADDI imm=2048, BEQ imm=3, op=12 -> no imem_we; err=1; err_cnt=3; count=0. A following legal ADD is written at addr 0.
- DEPTH=4: offer 6 instructions back-to-back -> exactly 4 writes (addr 0-3); in_ready falls after the 4th accept; full=1, done=1 without finish; the 5th and 6th are not accepted.
- Drop rst_n the cycle after an accept -> no imem_we, all outputs 0. Then start -> the next write lands at addr 0 with err cleared.
